// File: rtl/deserialize.sv
// deserialize: MSB-first serial-to-parallel receiver with frame abort; DESERIALIZE_PARITY_CHECK_EN adds a trailing even-parity bit
module deserialize #(
  parameter int WIDTH = 4
) (
  input  logic             input_clock1_1,
  input  logic             input_reset1_2,
  input  logic             input_serial_in,
  input  logic             input_shift_en,
  input  logic             input_frame_start,
  output logic [WIDTH-1:0] output_data,
  output logic             output_valid,
  output logic             output_busy,
  output logic             output_frame_err,
  output logic             output_parity_err
);
`ifdef DESERIALIZE_PARITY_CHECK_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS + 1);
  typedef enum logic {IDLE, RECV} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d, data_q, data_d, sr_shift;
  logic valid_q, ferr_q, perr_q, perr_d, start, take, last;
`ifdef DESERIALIZE_PARITY_CHECK_EN
  logic par_q, par_d;
`endif
  always_comb begin
    start = input_shift_en & input_frame_start;
    take = input_shift_en & ~input_frame_start & (state_q == RECV);
    last = take & (cnt_q == CW'(NBITS - 1));
    sr_shift = {sr_q[WIDTH-2:0], input_serial_in};
    cnt_d = start ? CW'(1) : last ? '0 : take ? cnt_q + 1'b1 : cnt_q;
    sr_d = start ? WIDTH'(input_serial_in) : (take & (cnt_q < CW'(WIDTH))) ? sr_shift : sr_q;
`ifdef DESERIALIZE_PARITY_CHECK_EN
    par_d = start ? input_serial_in : take ? par_q ^ input_serial_in : par_q;
    data_d = last ? sr_q : data_q;
    perr_d = last ? par_q ^ input_serial_in : perr_q;
`else
    data_d = last ? sr_shift : data_q;
    perr_d = 1'b0;
`endif
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (start ? RECV : IDLE) : (last ? IDLE : RECV);
  end
  always_comb begin
    output_busy = (state_q == RECV);
  end
  always_ff @(posedge input_clock1_1) begin
    if (input_reset1_2) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sr_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      data_q <= data_d;
      valid_q <= last;
      ferr_q <= start & (state_q == RECV);
      perr_q <= perr_d;
    end
  end
`ifdef DESERIALIZE_PARITY_CHECK_EN
  always_ff @(posedge input_clock1_1) begin
    if (input_reset1_2) par_q <= 1'b0;
    else par_q <= par_d;
  end
`endif
  assign output_data = data_q;
  assign output_valid = valid_q;
  assign output_frame_err = ferr_q;
  assign output_parity_err = perr_q;
endmodule

// File: tb/tb_deserialize.sv
// tb_deserialize: directed and random stimulus against a bit-queue reference model
module tb_deserialize;
  localparam int WIDTH = 4;
`ifdef DESERIALIZE_PARITY_CHECK_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif
  logic clk = 1'b0, rst = 1'b1, ser = 1'b0, en = 1'b0, fs = 1'b0;
  logic [WIDTH-1:0] dout;
  logic valid, busy, ferr, perr;
  int errors = 0, checks = 0;
  bit q[$];
  logic [WIDTH-1:0] e_data = '0;
  logic e_valid = 1'b0, e_ferr = 1'b0, e_perr = 1'b0;
  deserialize #(.WIDTH(WIDTH)) dut (
    .input_clock1_1(clk),
    .input_reset1_2(rst),
    .input_serial_in(ser),
    .input_shift_en(en),
    .input_frame_start(fs),
    .output_data(dout),
    .output_valid(valid),
    .output_busy(busy),
    .output_frame_err(ferr),
    .output_parity_err(perr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model();
    logic [WIDTH-1:0] w;
    bit p;
    e_valid = 1'b0;
    e_ferr = 1'b0;
    if (rst) begin
      q.delete();
      e_data = '0;
      e_perr = 1'b0;
    end else if (en && fs) begin
      e_ferr = (q.size() > 0);
      q.delete();
      q.push_back(ser);
    end else if (en && q.size() > 0) begin
      q.push_back(ser);
      if (q.size() == NB) begin
        w = '0;
        p = 1'b0;
        for (int i = 0; i < NB; i++) p ^= q[i];
        for (int i = 0; i < WIDTH; i++) w = {w[WIDTH-2:0], q[i]};
        e_data = w;
        e_valid = 1'b1;
`ifdef DESERIALIZE_PARITY_CHECK_EN
        e_perr = p;
`endif
        q.delete();
      end
    end
  endtask
  task automatic step(input logic r, input logic e, input logic f, input logic s);
    @(negedge clk);
    rst = r;
    en = e;
    fs = f;
    ser = s;
    @(posedge clk);
    model();
    #1;
    chk("data", 32'(dout), 32'(e_data));
    chk("valid", 32'(valid), 32'(e_valid));
    chk("busy", 32'(busy), 32'(q.size() > 0));
    chk("frame_err", 32'(ferr), 32'(e_ferr));
    chk("parity_err", 32'(perr), 32'(e_perr));
  endtask
  task automatic par_bit(input logic [WIDTH-1:0] v, input bit bad);
`ifdef DESERIALIZE_PARITY_CHECK_EN
    step(1'b0, 1'b1, 1'b0, (^v) ^ bad);
`endif
  endtask
  task automatic frame(input logic [WIDTH-1:0] v, input bit bad);
    for (int i = WIDTH - 1; i >= 0; i--) step(1'b0, 1'b1, i == WIDTH - 1, v[i]);
    par_bit(v, bad);
  endtask
  initial begin
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("reset_data", 32'(dout), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("idle_ignore_busy", 32'(busy), 32'h0);
    frame(4'b1011, 1'b0);
    chk("plan1_data", 32'(dout), 32'hB);
    chk("plan1_valid", 32'(valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("plan1_pulse", 32'(valid), 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("gap_hold_busy", 32'(busy), 32'h1);
      chk("gap_no_valid", 32'(valid), 32'h0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    par_bit(4'b1011, 1'b0);
    chk("gap_data", 32'(dout), 32'hB);
    chk("gap_valid", 32'(valid), 32'h1);
    frame(4'b0110, 1'b0);
    chk("b2b_first", 32'(dout), 32'h6);
    frame(4'b1001, 1'b0);
    chk("b2b_second", 32'(dout), 32'h9);
    chk("b2b_valid", 32'(valid), 32'h1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("abort_ferr", 32'(ferr), 32'h1);
    chk("abort_data_held", 32'(dout), 32'h9);
    chk("abort_busy", 32'(busy), 32'h1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("abort_ferr_pulse", 32'(ferr), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    par_bit(4'b0010, 1'b0);
    chk("abort_data", 32'(dout), 32'h2);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_data", 32'(dout), 32'h0);
    frame(4'b1111, 1'b0);
    chk("rst_mid_full", 32'(dout), 32'hF);
`ifdef DESERIALIZE_PARITY_CHECK_EN
    frame(4'b1011, 1'b0);
    chk("par_ok_err", 32'(perr), 32'h0);
    chk("par_ok_valid", 32'(valid), 32'h1);
    frame(4'b1011, 1'b1);
    chk("par_bad_err", 32'(perr), 32'h1);
    chk("par_bad_data", 32'(dout), 32'hB);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("par_err_hold", 32'(perr), 32'h1);
`else
    chk("par_tied", 32'(perr), 32'h0);
`endif
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 75,
           $urandom_range(0, 99) < 12, 1'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
